// File: rtl/mem_rw_initiator.sv
// Burst initiator for a single-port memory: takes read/write burst commands,
// drives one memory beat at a time and returns read beats over a
// valid/ready response channel. Every output is driven straight from a flop.
module mem_rw_initiator #(
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned MEM_DW = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_rw,
  input  logic [MEM_AW-1:0] i_cmd_addr,
  input  logic [7:0]        i_cmd_len,
  input  logic [MEM_DW-1:0] i_cmd_data,
  output logic              o_mem_valid,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic              o_mem_rw,
  output logic [MEM_DW-1:0] o_mem_data,
  input  logic [MEM_DW-1:0] i_mem_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [MEM_DW-1:0] o_rsp_data,
  output logic [MEM_AW-1:0] o_rsp_addr,
  output logic              o_rsp_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {StIdle, StWrite, StRdIssue, StRdWait, StRdRsp} state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [8:0]        beat_q, beat_d;  // 9 bits so a 256-beat burst never wraps
  logic              cmd_ready_q, cmd_ready_d;
  logic              mem_valid_q, mem_valid_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rw_q, mem_rw_d;
  logic [MEM_DW-1:0] mem_data_q, mem_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [MEM_DW-1:0] rsp_data_q, rsp_data_d;
  logic [MEM_AW-1:0] rsp_addr_q, rsp_addr_d;
  logic              rsp_last_q, rsp_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_beat;

  assign last_beat = (beat_q == {1'b0, len_q});

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beat_d      = beat_q;
    cmd_ready_d = cmd_ready_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_rw_d    = mem_rw_q;
    mem_data_d  = mem_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_last_d  = rsp_last_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          len_d       = i_cmd_len;
          beat_d      = '0;
          cmd_ready_d = 1'b0;
          mem_valid_d = 1'b1;
          mem_addr_d  = i_cmd_addr;
          mem_rw_d    = i_cmd_rw;
          if (i_cmd_rw) begin
            mem_data_d = i_cmd_data;
            state_d    = StWrite;
          end else begin
            state_d = StRdIssue;
          end
        end
      end
      StWrite: begin
        if (last_beat) begin
          mem_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          done_d      = 1'b1;
          state_d     = StIdle;
        end else begin
          beat_d     = beat_q + 9'd1;
          mem_addr_d = mem_addr_q + MEM_AW'(1);
          mem_data_d = mem_data_q + MEM_DW'(1);
        end
      end
      StRdIssue: begin
        mem_valid_d = 1'b0;
        state_d     = StRdWait;
      end
      StRdWait: begin
        // Memory output is valid this cycle; capture it with the beat address.
        rsp_valid_d = 1'b1;
        rsp_data_d  = i_mem_data;
        rsp_addr_d  = mem_addr_q;
        rsp_last_d  = last_beat;
        state_d     = StRdRsp;
      end
      StRdRsp: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            cmd_ready_d = 1'b1;
            done_d      = 1'b1;
            state_d     = StIdle;
          end else begin
            beat_d      = beat_q + 9'd1;
            mem_addr_d  = mem_addr_q + MEM_AW'(1);
            mem_valid_d = 1'b1;
            state_d     = StRdIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      beat_q      <= '0;
      cmd_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_rw_q    <= 1'b0;
      mem_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      cmd_ready_q <= cmd_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_rw_q    <= mem_rw_d;
      mem_data_q  <= mem_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_last_q  <= rsp_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_mem_valid = mem_valid_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_rw    = mem_rw_q;
  assign o_mem_data  = mem_data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_addr  = rsp_addr_q;
  assign o_rsp_last  = rsp_last_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_mem_rw_initiator.sv
// Directed bench for mem_rw_initiator with a behavioural single-port memory.
module tb_mem_rw_initiator;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_rw;
  logic [7:0]  i_cmd_addr;
  logic [7:0]  i_cmd_len;
  logic [31:0] i_cmd_data;
  logic        o_mem_valid;
  logic [7:0]  o_mem_addr;
  logic        o_mem_rw;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic [7:0]  o_rsp_addr;
  logic        o_rsp_last;
  logic        o_busy;
  logic        o_done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [256];

  mem_rw_initiator #(.MEM_AW(8), .MEM_DW(32)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_rw    (i_cmd_rw),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_len   (i_cmd_len),
    .i_cmd_data  (i_cmd_data),
    .o_mem_valid (o_mem_valid),
    .o_mem_addr  (o_mem_addr),
    .o_mem_rw    (o_mem_rw),
    .o_mem_data  (o_mem_data),
    .i_mem_data  (i_mem_data),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_addr  (o_rsp_addr),
    .o_rsp_last  (o_rsp_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Behavioural memory: writes on strobe, read data registered one cycle later.
  always @(posedge i_clk) begin
    if (o_mem_valid && o_mem_rw) mem[o_mem_addr] <= o_mem_data;
    if (o_mem_valid && !o_mem_rw) i_mem_data <= mem[o_mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic cmd(input logic rw, input logic [7:0] a, input logic [7:0] l,
                     input logic [31:0] d);
    i_cmd_valid = 1'b1;
    i_cmd_rw    = rw;
    i_cmd_addr  = a;
    i_cmd_len   = l;
    i_cmd_data  = d;
  endtask

  logic [7:0]  wa [4];
  logic [31:0] wd [4];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    i_mem_data  = 32'h0;
    i_cmd_valid = 1'b0;
    i_cmd_rw    = 1'b0;
    i_cmd_addr  = 8'h0;
    i_cmd_len   = 8'h0;
    i_cmd_data  = 32'h0;
    i_rsp_ready = 1'b0;
    wa[0] = 8'hFE; wa[1] = 8'hFF; wa[2] = 8'h00; wa[3] = 8'h01;
    wd[0] = 32'hFFFFFFFE; wd[1] = 32'hFFFFFFFF; wd[2] = 32'h0; wd[3] = 32'h1;

    // Reset with no clock edge yet.
    i_reset_n = 1'b1;
    #1 i_reset_n = 1'b0;
    #1;
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_mem_valid", o_mem_valid, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_data", o_mem_data, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_last", o_rsp_last, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    #1 i_reset_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", o_busy, 0);
    chk("idle_ready", o_cmd_ready, 1);

    // Single write.
    cmd(1'b1, 8'h10, 8'd0, 32'hDEADBEEF);
    tick();
    i_cmd_valid = 1'b0;
    chk("w1_valid", o_mem_valid, 1);
    chk("w1_rw", o_mem_rw, 1);
    chk("w1_addr", o_mem_addr, 8'h10);
    chk("w1_data", o_mem_data, 32'hDEADBEEF);
    chk("w1_busy", o_busy, 1);
    chk("w1_ready", o_cmd_ready, 0);
    chk("w1_nodone", o_done, 0);
    tick();
    chk("w1_done", o_done, 1);
    chk("w1_valid_off", o_mem_valid, 0);
    chk("w1_ready_back", o_cmd_ready, 1);
    chk("w1_busy_off", o_busy, 0);
    chk("w1_addr_hold", o_mem_addr, 8'h10);
    tick();
    chk("w1_done_pulse", o_done, 0);

    // Write with address and data wrap.
    cmd(1'b1, 8'hFE, 8'd3, 32'hFFFFFFFE);
    tick();
    i_cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_valid", o_mem_valid, 1);
      chk("wrap_addr", o_mem_addr, wa[k]);
      chk("wrap_data", o_mem_data, wd[k]);
      chk("wrap_nodone", o_done, 0);
      tick();
    end
    chk("wrap_done", o_done, 1);
    chk("wrap_valid_off", o_mem_valid, 0);

    // Read-back with consumer always ready: one beat per 3 cycles.
    i_rsp_ready = 1'b1;
    cmd(1'b0, 8'hFE, 8'd3, 32'h0);
    tick();
    i_cmd_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("rd_issue_valid", o_mem_valid, 1);
      chk("rd_issue_rw", o_mem_rw, 0);
      chk("rd_issue_addr", o_mem_addr, wa[b]);
      chk("rd_issue_rspv", o_rsp_valid, 0);
      tick();
      chk("rd_wait_valid", o_mem_valid, 0);
      chk("rd_wait_rspv", o_rsp_valid, 0);
      tick();
      chk("rd_rsp_valid", o_rsp_valid, 1);
      chk("rd_rsp_data", o_rsp_data, wd[b]);
      chk("rd_rsp_addr", o_rsp_addr, wa[b]);
      chk("rd_rsp_last", o_rsp_last, (b == 3) ? 1 : 0);
      chk("rd_rsp_memv", o_mem_valid, 0);
      chk("rd_rsp_nodone", o_done, 0);
      tick();
    end
    chk("rd_done", o_done, 1);
    chk("rd_ready_back", o_cmd_ready, 1);
    chk("rd_rspv_off", o_rsp_valid, 0);
    chk("rd_last_hold", o_rsp_last, 1);
    chk("rd_data_hold", o_rsp_data, 32'h1);

    // Backpressure: read 0xFF,0x00 with consumer stalled.
    i_rsp_ready = 1'b0;
    cmd(1'b0, 8'hFF, 8'd1, 32'h0);
    tick();
    i_cmd_valid = 1'b0;
    chk("bp_issue_addr", o_mem_addr, 8'hFF);
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold_valid", o_rsp_valid, 1);
      chk("bp_hold_data", o_rsp_data, 32'hFFFFFFFF);
      chk("bp_hold_addr", o_rsp_addr, 8'hFF);
      chk("bp_hold_last", o_rsp_last, 0);
      chk("bp_no_memv", o_mem_valid, 0);
      chk("bp_no_done", o_done, 0);
      tick();
    end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk("bp_beat1_memv", o_mem_valid, 1);
    chk("bp_beat1_addr", o_mem_addr, 8'h00);
    chk("bp_beat1_rspv", o_rsp_valid, 0);
    tick();
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("bp_b1_valid", o_rsp_valid, 1);
      chk("bp_b1_data", o_rsp_data, 32'h0);
      chk("bp_b1_addr", o_rsp_addr, 8'h00);
      chk("bp_b1_last", o_rsp_last, 1);
      chk("bp_b1_nodone", o_done, 0);
      tick();
    end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk("bp_done", o_done, 1);
    chk("bp_rspv_off", o_rsp_valid, 0);
    tick();

    // 256-beat write with a second command held pending the whole time.
    cmd(1'b1, 8'h00, 8'd255, 32'h100);
    tick();
    cmd(1'b1, 8'h80, 8'd0, 32'hAA);
    for (int k = 0; k < 256; k++) begin
      chk("long_valid", o_mem_valid, 1);
      chk("long_addr", o_mem_addr, k[7:0]);
      chk("long_data", o_mem_data, 32'h100 + k);
      chk("long_ready", o_cmd_ready, 0);
      tick();
    end
    chk("long_done", o_done, 1);
    chk("long_ready_back", o_cmd_ready, 1);
    chk("long_valid_off", o_mem_valid, 0);
    tick();
    i_cmd_valid = 1'b0;
    chk("held_valid", o_mem_valid, 1);
    chk("held_addr", o_mem_addr, 8'h80);
    chk("held_data", o_mem_data, 32'hAA);
    tick();
    chk("held_done", o_done, 1);
    tick();

    // Abort a long write at beat 100 with reset.
    cmd(1'b1, 8'h00, 8'd255, 32'h0);
    tick();
    i_cmd_valid = 1'b0;
    repeat (100) tick();
    chk("abort_beat100", o_mem_addr, 8'd100);
    chk("abort_valid_pre", o_mem_valid, 1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("abort_memv", o_mem_valid, 0);
    chk("abort_rspv", o_rsp_valid, 0);
    chk("abort_ready", o_cmd_ready, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_no_done", o_done, 0);
      chk("abort_idle_memv", o_mem_valid, 0);
    end

    // Fresh read after reset: 0x10 holds 0x10 from the aborted burst.
    i_rsp_ready = 1'b1;
    cmd(1'b0, 8'h10, 8'd0, 32'h0);
    tick();
    i_cmd_valid = 1'b0;
    chk("fresh_issue", o_mem_valid, 1);
    chk("fresh_rw", o_mem_rw, 0);
    tick();
    tick();
    chk("fresh_rspv", o_rsp_valid, 1);
    chk("fresh_data", o_rsp_data, 32'h10);
    chk("fresh_addr", o_rsp_addr, 8'h10);
    chk("fresh_last", o_rsp_last, 1);
    tick();
    chk("fresh_done", o_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_rw_initiator.md
# mem_rw_initiator

Command-driven initiator for the single-port `mem_rw` memory interface (valid / addr / rw / wdata in, registered rdata out one cycle later). It accepts burst commands (read or write, start address, beat count) over a valid/ready handshake and drives the memory port one beat at a time. Write data is generated as an incrementing pattern. Read data is returned beat by beat over a valid/ready response channel. It sits between a test/control agent and the memory, and is the requester side of that port.

## Interface
- `MEM_AW`, default 8: memory address width; addresses wrap modulo 2^MEM_AW.
- `MEM_DW`, default 32: memory data width.
- `i_clk` input 1: single clock; all logic on the rising edge.
- `i_reset_n` input 1: reset, asynchronous, active-low.
- `i_cmd_valid` input 1: command present.
- `o_cmd_ready` output 1: command accepted when high together with `i_cmd_valid` at a rising edge.
- `i_cmd_rw` input 1: 0 = read burst, 1 = write burst.
- `i_cmd_addr` input MEM_AW: start address.
- `i_cmd_len` input 8: beats minus 1 (0..255 = 1..256 beats).
- `i_cmd_data` input MEM_DW: write seed; beat k writes seed+k.
- `o_mem_valid` output 1: memory access strobe.
- `o_mem_addr` output MEM_AW: memory address.
- `o_mem_rw` output 1: 0 = read, 1 = write.
- `o_mem_data` output MEM_DW: memory write data.
- `i_mem_data` input MEM_DW: memory read data, valid the cycle after a read strobe.
- `o_rsp_valid` output 1: read beat available.
- `i_rsp_ready` input 1: consumer takes the beat.
- `o_rsp_data` output MEM_DW: read data.
- `o_rsp_addr` output MEM_AW: address the beat was read from.
- `o_rsp_last` output 1: final beat of the burst.
- `o_busy` output 1: high whenever state is not IDLE.
- `o_done` output 1: one-cycle pulse when a burst completes.

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_RSP.
- IDLE: `o_cmd_ready`=1. On accept, latch the command, clear the beat counter, and go to WRITE if rw=1, else RD_ISSUE.
- WRITE: one beat per cycle with `o_mem_valid`=1, `o_mem_rw`=1, addr=start+k (mod 2^MEM_AW), data=seed+k (mod 2^MEM_DW).
  - After beat len: go to IDLE and pulse `o_done` in the following cycle.
- RD_ISSUE: `o_mem_valid`=1, `o_mem_rw`=0 for exactly one cycle, addr=start+k. Then go to RD_WAIT.
- RD_WAIT: `o_mem_valid`=0. At the end of this cycle, capture `i_mem_data` into `o_rsp_data` and record the beat address into `o_rsp_addr`. Go to RD_RSP.
- RD_RSP: `o_rsp_valid`=1; `o_rsp_last`=1 iff k==len. Data and address are held stable until a handshake occurs.
  - On `i_rsp_ready`: if not last, k+1 and go to RD_ISSUE; if last, go to IDLE and pulse `o_done`.
- Exactly one memory access is ever outstanding. A read is never issued while a response is pending.
- `o_cmd_ready`=0 in all non-IDLE states. Commands presented while busy are neither accepted nor dropped; the source must hold them.
- Beat counter is 9 bits internally, or compared against len, so that len=255 executes 256 beats without overflow.

## Timing
- All outputs are registered.
- Reset values: `o_cmd_ready`=1, all other outputs 0, state IDLE.
- Reset asserted mid-burst aborts the burst immediately: `o_mem_valid` and `o_rsp_valid` drop asynchronously, remaining beats are lost, and there is no `o_done`.
- Command accepted at edge E: first memory beat is visible in cycle E+1.
- Write burst of N beats: `o_mem_valid` is high for cycles E+1..E+N, `o_done` is high in cycle E+N+1, `o_cmd_ready` returns high in cycle E+N+1.
  - A new command accepted at the end of E+N+1 gives back-to-back bursts with a 1-cycle gap.
- Read beat: issue cycle T, `i_mem_data` sampled at end of T+1, `o_rsp_valid` high from T+2.
  - With `i_rsp_ready` held high, throughput is 1 beat per 3 cycles.
- `o_mem_addr`, `o_mem_data`, `o_mem_rw` hold their last values while `o_mem_valid`=0.
- `o_rsp_data`, `o_rsp_addr`, `o_rsp_last` hold their last values after `o_rsp_valid` falls.
- `o_done` coincides with the first IDLE cycle.

## Test plan
- Reset: assert `i_reset_n`=0 with no clock edges -> all outputs 0 except `o_cmd_ready`=1. Release reset -> IDLE, `o_busy`=0.
- Single write: cmd rw=1, addr=0x10, len=0, data=0xDEADBEEF -> one cycle of valid/rw=1/addr 0x10/data 0xDEADBEEF at E+1. `o_done` at E+2.
- Write wrap: addr=0xFE, len=3, seed=0xFFFFFFFE -> four consecutive beats.
  - Addresses 0xFE, 0xFF, 0x00, 0x01; data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- Read-back with behavioural memory: after the wrap write, read addr=0xFE, len=3 with ready=1.
  - Four responses with the data above; `o_rsp_last` only on addr 0x01; beats spaced 3 cycles apart.
- Backpressure: read len=1 with `i_rsp_ready`=0 for 10 cycles.
  - `o_rsp_valid`/data/addr held stable; no second `o_mem_valid` until the handshake; `o_done` only after the last handshake.
- Busy and abort:
  - A command presented during a len=255 write is not accepted until `o_done`. Check exactly 256 beats, addresses 0x00..0xFF.
  - A repeat run with reset asserted at beat 100 -> outputs clear immediately, no `o_done`, and a fresh command is accepted after release.
